// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// i2c_pkg
// Shared state encodings and OLED control-byte constants for the I2C responder.
// Revision: 1.0
// ============================================================================
package i2c_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_ADDR   = 3'd1;
   localparam state_t ST_A_ACK  = 3'd2;
   localparam state_t ST_CTRL   = 3'd3;
   localparam state_t ST_C_ACK  = 3'd4;
   localparam state_t ST_DATA   = 3'd5;
   localparam state_t ST_D_ACK  = 3'd6;
   localparam state_t ST_IGNORE = 3'd7;

   localparam logic [7:0] CTRL_CMD    = 8'h00;
   localparam logic [7:0] CTRL_DATA   = 8'hC0;
   localparam logic [7:0] OLED_ADDR_W = 8'h78;

endpackage
`default_nettype wire

// File: rtl/i2c_line_sync.sv
`default_nettype none
// ============================================================================
// i2c_line_sync
// Synchronises scl/sda and emits registered scl edge, START and STOP pulses.
// Revision: 1.0
// ============================================================================
module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_scl,
   input  logic i_sda,
   output logic o_sda,
   output logic o_scl_rise,
   output logic o_scl_fall,
   output logic o_start,
   output logic o_stop
);

   logic [SYNC_STAGES-1:0] r_scl_sync;
   logic [SYNC_STAGES-1:0] r_sda_sync;
   logic                   r_scl_d;
   logic                   r_sda_d;
   logic                   r_scl_rise;
   logic                   r_scl_fall;
   logic                   r_start;
   logic                   r_stop;
   logic                   w_scl;
   logic                   w_sda;

   assign w_scl = r_scl_sync[SYNC_STAGES-1];
   assign w_sda = r_sda_sync[SYNC_STAGES-1];

   // Idle bus is high, so reset to 1 to avoid a false edge after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
         r_scl_d    <= 1'b1;
         r_sda_d    <= 1'b1;
         r_scl_rise <= 1'b0;
         r_scl_fall <= 1'b0;
         r_start    <= 1'b0;
         r_stop     <= 1'b0;
      end else begin
         r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
         r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
         r_scl_d    <= w_scl;
         r_sda_d    <= w_sda;
         r_scl_rise <= w_scl & ~r_scl_d;
         r_scl_fall <= ~w_scl & r_scl_d;
         r_start    <= w_scl & r_scl_d & r_sda_d & ~w_sda;
         r_stop     <= w_scl & r_scl_d & ~r_sda_d & w_sda;
      end
   end

   // r_sda_d is the sda level the registered pulses were derived from.
   assign o_sda      = r_sda_d;
   assign o_scl_rise = r_scl_rise;
   assign o_scl_fall = r_scl_fall;
   assign o_start    = r_start;
   assign o_stop     = r_stop;

endmodule
`default_nettype wire

// File: rtl/i2c_oled_responder.sv
`default_nettype none
// ============================================================================
// i2c_oled_responder
// Write-only I2C target decoding OLED control/command/pixel byte streams.
// Revision: 1.0
// ============================================================================
import i2c_pkg::*;

module i2c_oled_responder #(
   parameter logic [6:0] SLAVE_ADDR  = OLED_ADDR_W[7:1],
   parameter int         ADDR_W      = 10,
   parameter int         SYNC_STAGES = 2
) (
   input  logic              clk2,
   input  logic              reset,
   input  logic              scl,
   input  logic              sda,
   output logic              sda_low,
   output logic              cmd_valid,
   output logic [7:0]        cmd_data,
   output logic              pix_we,
   output logic [ADDR_W-1:0] pix_addr,
   output logic [7:0]        pix_data,
   output logic              busy
);

   logic              w_sda;
   logic              w_scl_rise;
   logic              w_scl_fall;
   logic              w_start;
   logic              w_stop;
   logic [7:0]        w_byte;
   logic              w_last_bit;
   logic              w_addr_hit;
   state_t            w_ack_next;

   state_t            r_state;
   logic              r_ack_hold;
   logic [2:0]        r_bit_cnt;
   logic [6:0]        r_shift;
   logic              r_co;
   logic              r_dc;
   logic [ADDR_W-1:0] r_ptr;
   logic              r_sda_low;
   logic              r_cmd_valid;
   logic [7:0]        r_cmd_data;
   logic              r_pix_we;
   logic [ADDR_W-1:0] r_pix_addr;
   logic [7:0]        r_pix_data;
   logic              r_busy;

   i2c_line_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_line_sync (
      .clk        (clk2),
      .rst_n      (reset),
      .i_scl      (scl),
      .i_sda      (sda),
      .o_sda      (w_sda),
      .o_scl_rise (w_scl_rise),
      .o_scl_fall (w_scl_fall),
      .o_start    (w_start),
      .o_stop     (w_stop)
   );

   assign w_byte     = {r_shift, w_sda};
   assign w_last_bit = (r_bit_cnt == 3'd7);
   assign w_addr_hit = (w_byte[7:1] == SLAVE_ADDR) && !w_byte[0];

   always_comb begin
      w_ack_next = ST_IDLE;
      case (r_state)
         ST_A_ACK: w_ack_next = ST_CTRL;
         ST_C_ACK: w_ack_next = ST_DATA;
         ST_D_ACK: w_ack_next = r_co ? ST_CTRL : ST_DATA;
         default:  w_ack_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk2 or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_ack_hold  <= 1'b0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_co        <= 1'b0;
         r_dc        <= 1'b0;
         r_ptr       <= '0;
         r_sda_low   <= 1'b0;
         r_cmd_valid <= 1'b0;
         r_cmd_data  <= '0;
         r_pix_we    <= 1'b0;
         r_pix_addr  <= '0;
         r_pix_data  <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_cmd_valid <= 1'b0;
         r_pix_we    <= 1'b0;
         if (w_start) begin
            r_state    <= ST_ADDR;
            r_bit_cnt  <= '0;
            r_ack_hold <= 1'b0;
            r_sda_low  <= 1'b0;
         end else if (w_stop) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_ack_hold <= 1'b0;
            r_sda_low  <= 1'b0;
            r_busy     <= 1'b0;
         end else begin
            case (r_state)
               ST_ADDR, ST_CTRL, ST_DATA: begin
                  if (w_scl_rise) begin
                     r_shift   <= w_byte[6:0];
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     if (w_last_bit) begin
                        if (r_state == ST_ADDR) begin
                           r_state <= w_addr_hit ? ST_A_ACK : ST_IGNORE;
                           r_busy  <= w_addr_hit;
                        end else if (r_state == ST_CTRL) begin
                           r_co    <= w_byte[7];
                           r_dc    <= w_byte[6];
                           r_state <= ST_C_ACK;
                        end else begin
                           r_state <= ST_D_ACK;
                           if (r_dc) begin
                              r_pix_we   <= 1'b1;
                              r_pix_data <= w_byte;
                              r_pix_addr <= r_ptr;
                              r_ptr      <= r_ptr + 1'b1;
                           end else begin
                              r_cmd_valid <= 1'b1;
                              r_cmd_data  <= w_byte;
                           end
                        end
                     end
                  end
               end
               // First fall after bit 8 drives the ACK, the following fall releases it.
               ST_A_ACK, ST_C_ACK, ST_D_ACK: begin
                  if (w_scl_fall) begin
                     if (!r_ack_hold) begin
                        r_sda_low  <= 1'b1;
                        r_ack_hold <= 1'b1;
                     end else begin
                        r_sda_low  <= 1'b0;
                        r_ack_hold <= 1'b0;
                        r_state    <= w_ack_next;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign sda_low   = r_sda_low;
   assign cmd_valid = r_cmd_valid;
   assign cmd_data  = r_cmd_data;
   assign pix_we    = r_pix_we;
   assign pix_addr  = r_pix_addr;
   assign pix_data  = r_pix_data;
   assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_oled_responder.sv
`default_nettype none
// ============================================================================
// tb_i2c_oled_responder
// Directed bus-level bench for the OLED I2C responder.
// Revision: 1.0
// ============================================================================
module tb_i2c_oled_responder;
   import i2c_pkg::*;

   localparam int ADDR_W = 10;

   logic              clk2 = 1'b0;
   logic              reset = 1'b0;
   logic              m_scl = 1'b1;
   logic              m_sda = 1'b1;
   logic              w_bus_sda;
   logic              sda_low;
   logic              cmd_valid;
   logic [7:0]        cmd_data;
   logic              pix_we;
   logic [ADDR_W-1:0] pix_addr;
   logic [7:0]        pix_data;
   logic              busy;

   int checks = 0;
   int errors = 0;
   int n_cmd = 0;
   int n_pix = 0;
   int n_overlap = 0;
   int n_low_cycles = 0;
   logic [7:0]        cmd_log  [64];
   logic [ADDR_W-1:0] paddr_log[64];
   logic [7:0]        pdata_log[64];

   // Open-drain bus: target can only pull the line low.
   assign w_bus_sda = m_sda & ~sda_low;

   i2c_oled_responder #(
      .SLAVE_ADDR  (7'h3C),
      .ADDR_W      (ADDR_W),
      .SYNC_STAGES (2)
   ) dut (
      .clk2      (clk2),
      .reset     (reset),
      .scl       (m_scl),
      .sda       (w_bus_sda),
      .sda_low   (sda_low),
      .cmd_valid (cmd_valid),
      .cmd_data  (cmd_data),
      .pix_we    (pix_we),
      .pix_addr  (pix_addr),
      .pix_data  (pix_data),
      .busy      (busy)
   );

   always #5 clk2 = ~clk2;

   always @(negedge clk2) begin
      if (cmd_valid) begin
         if (n_cmd < 64) cmd_log[n_cmd] = cmd_data;
         n_cmd++;
      end
      if (pix_we) begin
         if (n_pix < 64) begin
            paddr_log[n_pix] = pix_addr;
            pdata_log[n_pix] = pix_data;
         end
         n_pix++;
      end
      if (cmd_valid && pix_we) n_overlap++;
      if (sda_low) n_low_cycles++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk2);
   endtask

   task automatic bus_start();
      m_sda = 1'b1; wait_clk(4);
      m_scl = 1'b1; wait_clk(8);
      m_sda = 1'b0; wait_clk(8);
      m_scl = 1'b0; wait_clk(4);
   endtask

   task automatic bus_stop();
      m_sda = 1'b0; wait_clk(4);
      m_scl = 1'b1; wait_clk(8);
      m_sda = 1'b1; wait_clk(8);
   endtask

   task automatic send_bits(input logic [7:0] b, input int nbits);
      for (int i = 7; i > 7 - nbits; i--) begin
         m_sda = b[i]; wait_clk(4);
         m_scl = 1'b1; wait_clk(8);
         m_scl = 1'b0; wait_clk(4);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      send_bits(b, 8);
      m_sda = 1'b1; wait_clk(4);
      m_scl = 1'b1; wait_clk(4);
      ack = sda_low;
      wait_clk(4);
      m_scl = 1'b0; wait_clk(4);
   endtask

   task automatic test_reset();
      wait_clk(3);
      checks++;
      if ({sda_low, cmd_valid, pix_we, busy} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 0000", {sda_low, cmd_valid, pix_we, busy});
      end
      checks++;
      if ({cmd_data, pix_data, pix_addr} !== '0) begin
         errors++;
         $display("FAIL reset_data: got %h/%h/%h expected 0", cmd_data, pix_data, pix_addr);
      end
      reset = 1'b1;
      wait_clk(4);
   endtask

   task automatic test_cmd_write();
      int   bc, bp, acks;
      logic a;
      bc = n_cmd; bp = n_pix; acks = 0;
      bus_start();
      send_byte(8'h78, a); acks += int'(a);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL cmd_busy_after_addr: got %b expected 1", busy);
      end
      send_byte(CTRL_CMD, a); acks += int'(a);
      send_byte(8'hAF, a);    acks += int'(a);
      bus_stop();
      wait_clk(6);
      checks++;
      if (acks !== 3) begin
         errors++;
         $display("FAIL cmd_acks: got %0d expected 3", acks);
      end
      checks++;
      if ((n_cmd - bc) !== 1 || cmd_log[bc] !== 8'hAF) begin
         errors++;
         $display("FAIL cmd_strobe: got %0d strobes data %h expected 1 data af", n_cmd - bc, cmd_log[bc]);
      end
      checks++;
      if ((n_pix - bp) !== 0 || busy !== 1'b0 || cmd_data !== 8'hAF) begin
         errors++;
         $display("FAIL cmd_after_stop: got pix %0d busy %b cmd_data %h expected 0 0 af", n_pix - bp, busy, cmd_data);
      end
   endtask

   task automatic test_pixel_writes();
      int   bc, bp, acks;
      logic a;
      bc = n_cmd; bp = n_pix; acks = 0;
      bus_start();
      send_byte(8'h78, a); acks += int'(a);
      for (int k = 0; k < 3; k++) begin
         send_byte(CTRL_DATA, a); acks += int'(a);
         send_byte(8'h5A, a);     acks += int'(a);
      end
      bus_stop();
      wait_clk(6);
      checks++;
      if (acks !== 7 || (n_cmd - bc) !== 0) begin
         errors++;
         $display("FAIL pix_acks_nocmd: got acks %0d cmds %0d expected 7 0", acks, n_cmd - bc);
      end
      checks++;
      if ((n_pix - bp) !== 3) begin
         errors++;
         $display("FAIL pix_count: got %0d expected 3", n_pix - bp);
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (paddr_log[bp + k] !== ADDR_W'(k) || pdata_log[bp + k] !== 8'h5A) begin
            errors++;
            $display("FAIL pix_write%0d: got addr %0d data %h expected addr %0d data 5a",
                     k, paddr_log[bp + k], pdata_log[bp + k], k);
         end
      end
   endtask

   task automatic test_wrong_addr();
      int   bc, bp, bl, acks;
      logic a;
      bc = n_cmd; bp = n_pix; bl = n_low_cycles; acks = 0;
      bus_start();
      send_byte(8'h7A, a); acks += int'(a);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL nack_busy: got %b expected 0", busy);
      end
      send_byte(CTRL_CMD, a); acks += int'(a);
      send_byte(8'h11, a);    acks += int'(a);
      bus_stop();
      wait_clk(6);
      checks++;
      if (acks !== 0 || (n_low_cycles - bl) !== 0) begin
         errors++;
         $display("FAIL nack_sda: got acks %0d low cycles %0d expected 0 0", acks, n_low_cycles - bl);
      end
      checks++;
      if ((n_cmd - bc) !== 0 || (n_pix - bp) !== 0) begin
         errors++;
         $display("FAIL nack_strobes: got cmd %0d pix %0d expected 0 0", n_cmd - bc, n_pix - bp);
      end
   endtask

   task automatic test_abort();
      int   bc, acks;
      logic a;
      bc = n_cmd; acks = 0;
      bus_start();
      send_byte(8'h78, a);    acks += int'(a);
      send_byte(CTRL_CMD, a); acks += int'(a);
      send_bits(8'hE4, 4);
      bus_stop();
      wait_clk(6);
      checks++;
      if (acks !== 2 || (n_cmd - bc) !== 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_partial: got acks %0d cmds %0d busy %b expected 2 0 0", acks, n_cmd - bc, busy);
      end
   endtask

   task automatic test_ptr_wrap();
      int   bp;
      logic a;
      bp = n_pix;
      force dut.r_ptr = 10'd1023;
      wait_clk(1);
      release dut.r_ptr;
      wait_clk(1);
      bus_start();
      send_byte(8'h78, a);
      send_byte(CTRL_DATA, a);
      send_byte(8'h33, a);
      send_byte(CTRL_DATA, a);
      send_byte(8'h44, a);
      bus_stop();
      wait_clk(6);
      checks++;
      if ((n_pix - bp) !== 2 || paddr_log[bp] !== 10'd1023 || pdata_log[bp] !== 8'h33) begin
         errors++;
         $display("FAIL wrap_top: got n %0d addr %0d data %h expected 2 1023 33", n_pix - bp, paddr_log[bp], pdata_log[bp]);
      end
      checks++;
      if (paddr_log[bp + 1] !== 10'd0 || pdata_log[bp + 1] !== 8'h44) begin
         errors++;
         $display("FAIL wrap_zero: got addr %0d data %h expected 0 44", paddr_log[bp + 1], pdata_log[bp + 1]);
      end
   endtask

   task automatic test_cmd_stream();
      int         bc, bp, acks;
      logic       a;
      logic [7:0] exp_cmd [3];
      exp_cmd = '{8'hA1, 8'hC8, 8'h81};
      bc = n_cmd; bp = n_pix; acks = 0;
      bus_start();
      send_byte(8'h78, a);    acks += int'(a);
      send_byte(CTRL_CMD, a); acks += int'(a);
      for (int k = 0; k < 3; k++) begin
         send_byte(exp_cmd[k], a); acks += int'(a);
      end
      bus_stop();
      wait_clk(6);
      checks++;
      if (acks !== 5 || (n_cmd - bc) !== 3 || (n_pix - bp) !== 0) begin
         errors++;
         $display("FAIL stream_counts: got acks %0d cmds %0d pix %0d expected 5 3 0", acks, n_cmd - bc, n_pix - bp);
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (cmd_log[bc + k] !== exp_cmd[k]) begin
            errors++;
            $display("FAIL stream_cmd%0d: got %h expected %h", k, cmd_log[bc + k], exp_cmd[k]);
         end
      end
   endtask

   task automatic test_reset_mid_ack();
      int   bp, acks;
      logic a;
      bus_start();
      send_bits(8'h78, 8);
      m_sda = 1'b1; wait_clk(4);
      m_scl = 1'b1; wait_clk(4);
      checks++;
      if (sda_low !== 1'b1) begin
         errors++;
         $display("FAIL mid_ack_drive: got %b expected 1", sda_low);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (sda_low !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_ack_reset: got sda_low %b busy %b expected 0 0", sda_low, busy);
      end
      checks++;
      if ({cmd_data, pix_data, pix_addr} !== '0) begin
         errors++;
         $display("FAIL mid_ack_reset_data: got %h/%h/%h expected 0", cmd_data, pix_data, pix_addr);
      end
      wait_clk(2);
      reset = 1'b1;
      wait_clk(2);
      m_scl = 1'b0; wait_clk(4);
      bp = n_pix; acks = 0;
      bus_start();
      send_byte(8'h78, a);     acks += int'(a);
      send_byte(CTRL_DATA, a); acks += int'(a);
      send_byte(8'h77, a);     acks += int'(a);
      bus_stop();
      wait_clk(6);
      checks++;
      if (acks !== 3 || (n_pix - bp) !== 1 || paddr_log[bp] !== 10'd0 || pdata_log[bp] !== 8'h77) begin
         errors++;
         $display("FAIL post_reset_write: got acks %0d n %0d addr %0d data %h expected 3 1 0 77",
                  acks, n_pix - bp, paddr_log[bp], pdata_log[bp]);
      end
   endtask

   initial begin
      test_reset();
      test_cmd_write();
      test_pixel_writes();
      test_wrong_addr();
      test_abort();
      test_ptr_wrap();
      test_cmd_stream();
      test_reset_mid_ack();
      checks++;
      if (n_overlap !== 0) begin
         errors++;
         $display("FAIL strobe_overlap: got %0d expected 0", n_overlap);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
